pacman_sprite_drawer: RTL and testbench
=======================================

Name: pacman_sprite_drawer

Overview:
- Downstream of the Pacman movement controller; consumes its position (x, y) and direction each game tick.
- Redraws the 5x5 Pacman sprite into the 160x120, 3-bit-colour VGA frame buffer: erases the sprite at the previous position, then draws it at the new position with the mouth facing the current direction.
- Drives the VGA adapter pixel-write port at one pixel per clock.

Parameters:
- SCREEN_W, 160, horizontal resolution; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, vertical resolution; pixels with y >= SCREEN_H are clipped.
- PAC_COLOUR, 3'b110, colour of lit sprite pixels.
- BG_COLOUR, 3'b000, background/erase colour.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request redraw; sampled only in IDLE.
- x_in  in  8  sprite top-left x, latched on accepted start.
- y_in  in  7  sprite top-left y, latched on accepted start.
- dir_in  in  3  direction code: RIGHT=0, UP=1, LEFT=2, DOWN=3, WAIT=4; values 5-7 are treated as WAIT.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the redraw completes.
- vga_x  out  8  pixel x to write.
- vga_y  out  7  pixel y to write.
- vga_colour  out  3  pixel colour.
- plot  out  1  pixel write enable.

Behaviour:
- States: IDLE, ERASE, DRAW, DONE.
- Internal registers:
  - new_x/new_y/new_dir, latched on accepted start.
  - old_x/old_y, the last drawn position.
  - old_valid, set once a sprite has been drawn.
  - col/row counters, 3 bits each.
- Reset (synchronous, any state, including mid-redraw):
  - state=IDLE, old_valid=0, col=row=0.
  - busy=0, done=0, plot=0, vga_x=0, vga_y=0, vga_colour=0.
  - Any redraw in progress is abandoned with no done pulse.
- IDLE:
  - If start=1, latch x_in/y_in/dir_in and clear col/row.
  - Go to ERASE if old_valid=1, else go to DRAW.
  - start seen while busy is ignored; it is neither queued nor able to corrupt the latched values.
- Scan order: raster, col 0..4 fastest, then row 0..4. That is 25 cycles per pass, one pixel per cycle.
- ERASE: vga_x=old_x+col, vga_y=old_y+row, colour=BG_COLOUR. After (col,row)=(4,4), clear counters and go to DRAW.
- DRAW: vga_x=new_x+col, vga_y=new_y+row, colour = lit ? PAC_COLOUR : BG_COLOUR. After (4,4), go to DONE.
- DONE (one cycle): done=1, plot=0, old_x<=new_x, old_y<=new_y, old_valid<=1; then go to IDLE.
- Outputs are combinational from the state and counter registers:
  - plot=1 in ERASE/DRAW unless the pixel is clipped; plot=0 in IDLE/DONE.
  - Clipped pixels still consume their cycle.
- Clipping: compute the 9-bit sums x+col and 8-bit sums y+row. If x+col >= SCREEN_W or y+row >= SCREEN_H, then plot=0. The address wraps to no other pixel.
- Sprite mask, local (col,row):
  - disc = all 25 cells except the four corners (0,0),(4,0),(0,4),(4,4).
  - RIGHT mouth: row==2 && col>=2.
  - LEFT mouth: row==2 && col<=2.
  - UP mouth: col==2 && row<=2.
  - DOWN mouth: col==2 && row>=2.
  - WAIT: no mouth.
  - lit = disc && !mouth.
- Latency, with the start-accept edge as cycle 0:
  - With erase: ERASE plots in cycles 1-25, DRAW in 26-50, done in 51, IDLE (new start accepted) in 52.
  - First draw (old_valid=0): DRAW in 1-25, done in 26.
- start asserted in the same cycle done=1 is ignored; it is accepted only in IDLE.

Decomposition:
- Shared package pacman_pkg holds:
  - direction codes (DIR_RIGHT/UP/LEFT/DOWN/WAIT, 3 bits);
  - SCREEN_W/SCREEN_H;
  - colour constants;
  - SPRITE_SIZE=5.
- The movement controller shares this package.
- One sub-module, pacman_sprite_mask: combinational (dir, col, row) -> lit.

Test Plan:
- Reset, then start with x_in=10, y_in=20, dir=RIGHT -> no erase pass; 25 plots at (10..14, 20..24) in raster order. Colour 3'b110 except corners (10,20)/(14,20)/(10,24)/(14,24) and (12..14,22), which are 3'b000. done in cycle 26.
- Second start with x=11, y=20, dir=UP -> 25 erase plots at (10..14, 20..24), all 3'b000; then 25 draw plots at (11..15, 20..24) with (13,20..22) background. done in cycle 51, busy low in cycle 52.
- Start with x=157, y=117, dir=WAIT on a first draw -> plot=1 only for cols 0-2, rows 0-2 (9 writes, corner (157,117) is background). 25 cycles still elapse; done in cycle 26.
- Pulse start at cycles 5 and 30 during a redraw with different x_in -> ignored; drawn pixels use the originally latched position.
- Assert reset_n=0 at cycle 12 of a DRAW pass -> next cycle plot=0, busy=0, no done. A following start draws with no erase pass (old_valid cleared).
- dir_in=3'b111 -> drawn identically to WAIT (full disc, no mouth).

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared Pacman definitions: direction codes, screen geometry, colours and FSM states.
package pacman_pkg;

    localparam logic [2:0] DIR_RIGHT = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_WAIT  = 3'd4;

    localparam logic [8:0] SCREEN_W = 9'd160;
    localparam logic [7:0] SCREEN_H = 8'd120;

    localparam logic [2:0] PAC_COLOUR = 3'b110;
    localparam logic [2:0] BG_COLOUR  = 3'b000;

    localparam logic [2:0] SPRITE_SIZE = 3'd5;
    localparam logic [2:0] SPRITE_LAST = SPRITE_SIZE - 3'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/pacman_sprite_mask.sv
// 5x5 Pacman shape: round disc with a mouth cut toward the travel direction.
module pacman_sprite_mask
    import pacman_pkg::*;
(
    input  logic [2:0] dir,
    input  logic [2:0] col,
    input  logic [2:0] row,
    output logic       lit
);

    logic corner;
    logic mouth;

    always_comb begin
        corner = (col == 3'd0 || col == 3'd4) && (row == 3'd0 || row == 3'd4);
        // Codes 5-7 fall to default, so they draw like WAIT.
        case (dir)
            DIR_RIGHT: mouth = (row == 3'd2) && (col >= 3'd2);
            DIR_LEFT:  mouth = (row == 3'd2) && (col <= 3'd2);
            DIR_UP:    mouth = (col == 3'd2) && (row <= 3'd2);
            DIR_DOWN:  mouth = (col == 3'd2) && (row >= 3'd2);
            default:   mouth = 1'b0;
        endcase
        lit = !corner && !mouth;
    end

endmodule

// File: rtl/pacman_sprite_drawer.sv
// Erases Pacman at its previous position, then redraws it at the new one, one pixel per clock.
module pacman_sprite_drawer
    import pacman_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] dir_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot
);

    draw_state_t state;
    logic [7:0]  new_x, old_x;
    logic [6:0]  new_y, old_y;
    logic [2:0]  new_dir;
    logic        old_valid;
    logic [2:0]  col, row;
    logic        last_px;
    logic        lit;

    assign last_px = (col == SPRITE_LAST) && (row == SPRITE_LAST);

    pacman_sprite_mask mask (
        .dir (new_dir),
        .col (col),
        .row (row),
        .lit (lit)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            old_valid <= 1'b0;
            col       <= 3'd0;
            row       <= 3'd0;
            new_x     <= 8'd0;
            new_y     <= 7'd0;
            new_dir   <= DIR_WAIT;
            old_x     <= 8'd0;
            old_y     <= 7'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        new_x   <= x_in;
                        new_y   <= y_in;
                        new_dir <= dir_in;
                        col     <= 3'd0;
                        row     <= 3'd0;
                        state   <= old_valid ? S_ERASE : S_DRAW;
                    end
                end
                S_ERASE, S_DRAW: begin
                    if (last_px) begin
                        col   <= 3'd0;
                        row   <= 3'd0;
                        state <= (state == S_ERASE) ? S_DRAW : S_DONE;
                    end else if (col == SPRITE_LAST) begin
                        col <= 3'd0;
                        row <= row + 3'd1;
                    end else begin
                        col <= col + 3'd1;
                    end
                end
                S_DONE: begin
                    old_x     <= new_x;
                    old_y     <= new_y;
                    old_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sums are one bit wider than the screen coordinate so off-edge pixels clip rather than wrap.
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       active;

    always_comb begin
        active = (state == S_ERASE) || (state == S_DRAW);
        if (state == S_ERASE) begin
            sum_x = {1'b0, old_x} + {6'd0, col};
            sum_y = {1'b0, old_y} + {5'd0, row};
        end else begin
            sum_x = {1'b0, new_x} + {6'd0, col};
            sum_y = {1'b0, new_y} + {5'd0, row};
        end
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        plot       = active && (sum_x < SCREEN_W) && (sum_y < SCREEN_H);
        vga_x      = active ? sum_x[7:0] : 8'd0;
        vga_y      = active ? sum_y[6:0] : 7'd0;
        vga_colour = (state == S_DRAW && lit) ? PAC_COLOUR : BG_COLOUR;
    end

endmodule

// File: tb/tb_pacman_sprite_drawer.sv
// Scoreboard bench for the Pacman sprite drawer: expected pixel writes queued per redraw.
module tb_pacman_sprite_drawer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x_in = 8'd0;
    logic [6:0] y_in = 7'd0;
    logic [2:0] dir_in = 3'd0;
    logic       busy, done, plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int n_vec = 0;
    int n_err = 0;
    logic [17:0] sb[$];
    bit   m_old_valid = 0;
    int   m_ox = 0, m_oy = 0;

    always #5 clock = ~clock;

    pacman_sprite_drawer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .x_in       (x_in),
        .y_in       (y_in),
        .dir_in     (dir_in),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_lit(input int d, input int c, input int r);
        bit corner = (c == 0 || c == 4) && (r == 0 || r == 4);
        bit mouth;
        case (d)
            0: mouth = (r == 2 && c >= 2);
            1: mouth = (c == 2 && r <= 2);
            2: mouth = (r == 2 && c <= 2);
            3: mouth = (c == 2 && r >= 2);
            default: mouth = 0;
        endcase
        return !corner && !mouth;
    endfunction

    always @(negedge clock) begin
        if (reset_n && plot) begin
            if (sb.size() == 0) chk("extra_plot", 32'(vga_x), 32'hffff);
            else chk("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(sb.pop_front()));
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_outs", 32'({busy, done, plot, vga_x, vga_y, vga_colour}), 32'd0);
        sb.delete();
        m_old_valid = 0;
        reset_n = 1'b1;
    endtask

    task automatic push_expected(input int x, input int y, input int d);
        if (m_old_valid)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    if (m_ox + c < 160 && m_oy + r < 120)
                        sb.push_back({8'(m_ox + c), 7'(m_oy + r), 3'b000});
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (x + c < 160 && y + r < 120)
                    sb.push_back({8'(x + c), 7'(y + r), ref_lit(d, c, r) ? 3'b110 : 3'b000});
    endtask

    // Cycle numbering: the start-accept edge is cycle 0; checks sample on the following negedges.
    task automatic redraw(input int x, input int y, input int d, input bit glitch);
        int cyc_done = 0;
        int exp_done = m_old_valid ? 51 : 26;
        push_expected(x, y, d);
        @(negedge clock);
        start = 1'b1; x_in = 8'(x); y_in = 7'(y); dir_in = 3'(d);
        for (int cyc = 1; cyc <= 60 && cyc_done == 0; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (cyc == 1) chk("busy_c1", 32'(busy), 32'd1);
            if (glitch && (cyc == 5 || cyc == 30)) begin
                start = 1'b1; x_in = 8'd200; y_in = 7'd5; dir_in = 3'd1;
            end
            if (done) cyc_done = cyc;
        end
        chk("done_cyc", 32'(cyc_done), 32'(exp_done));
        if (glitch) begin
            start = 1'b1; x_in = 8'd200; y_in = 7'd5;
        end
        @(negedge clock);
        start = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        if (glitch) begin
            @(negedge clock);
            chk("start_at_done_ignored", 32'(busy), 32'd0);
        end
        sb.delete();
        m_old_valid = 1; m_ox = x; m_oy = y;
    endtask

    initial begin
        do_reset();
        redraw(10, 20, 0, 0);
        redraw(11, 20, 1, 0);
        redraw(30, 40, 3, 1);
        do_reset();
        redraw(157, 117, 4, 0);
        redraw(50, 60, 7, 0);

        // Reset partway through a first-draw pass.
        do_reset();
        push_expected(20, 30, 2);
        @(negedge clock);
        start = 1'b1; x_in = 8'd20; y_in = 7'd30; dir_in = 3'd2;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clock);
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clock);
        chk("mid_reset_outs", 32'({busy, done, plot}), 32'd0);
        reset_n = 1'b1;
        sb.delete();
        m_old_valid = 0;
        begin
            int saw_done = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (done) saw_done++;
            end
            chk("no_done_after_reset", 32'(saw_done), 32'd0);
        end
        redraw(70, 80, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
